// File: rtl/bcd_clock_pkg.sv
// bcd_clock_pkg: shared state encoding and BCD helpers for the shot clock
package bcd_clock_pkg;
  typedef enum logic [1:0] {S_STOP, S_RUN, S_EXPIRED} state_t;
  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  function automatic logic [3:0] bcd_sat(input logic [3:0] n);
    return n > 4'd9 ? 4'd9 : n;
  endfunction
endpackage

// File: rtl/bcd_dec_digit.sv
// bcd_dec_digit: one BCD digit decrement with borrow chain
module bcd_dec_digit (
  input  logic [3:0] d,
  input  logic       bin,
  output logic [3:0] q,
  output logic       bout
);
  assign q    = bin ? (d == 4'd0 ? 4'd9 : d - 4'd1) : d;
  assign bout = bin & (d == 4'd0);
endmodule

// File: rtl/bcd_shot_clock.sv
// bcd_shot_clock: N-digit BCD shot clock with presets, prescaler, FSM and buzzer
module bcd_shot_clock
  import bcd_clock_pkg::*;
#(
  parameter int DIGITS             = 2,
  parameter int PRESET_FULL        = 24,
  parameter int PRESET_SHORT       = 14,
  parameter int SHORT_ONLY_IF_LESS = 1,
  parameter int TICK_DIV           = 50_000_000,
  parameter int BUZZ_CYCLES        = 100_000_000
) (
  input  logic                CP,
  input  logic                CR,
  input  logic                RUN,
  input  logic                LD_FULL,
  input  logic                LD_SHORT,
  input  logic                PE,
  input  logic [4*DIGITS-1:0] D,
  output logic [4*DIGITS-1:0] Q,
  output logic                TICK,
  output logic                TC,
  output logic                BUZZ,
  output logic                RUNNING
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BUZZ_CYCLES + 1);
  localparam logic [31:0] FULL_W  = to_bcd(PRESET_FULL);
  localparam logic [31:0] SHORT_W = to_bcd(PRESET_SHORT);
  localparam logic [W-1:0] FULL_BCD  = FULL_W[W-1:0];
  localparam logic [W-1:0] SHORT_BCD = SHORT_W[W-1:0];
  state_t        state;
  logic [PW-1:0] presc;
  logic [BW-1:0] bcnt;
  logic [W-1:0]  d_sat, q_dec, ld_val;
  logic [DIGITS:0] b;
  logic q_zero, short_ok, ld, go, wrap, dec_zero;
  assign b[0] = 1'b1;
  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_dig
      bcd_dec_digit u_dig (
        .d    (Q[4*i+:4]),
        .bin  (b[i]),
        .q    (q_dec[4*i+:4]),
        .bout (b[i+1])
      );
      assign d_sat[4*i+:4] = bcd_sat(D[4*i+:4]);
    end
  endgenerate
  // a borrow out of the top digit means every digit was zero
  assign q_zero   = b[DIGITS];
  assign dec_zero = q_dec == '0;
  assign short_ok = SHORT_ONLY_IF_LESS == 0 || Q < SHORT_BCD;
  // an asserted LD_SHORT masks PE even when the short load is refused
  assign ld       = LD_FULL | (LD_SHORT & short_ok) | (PE & ~LD_SHORT);
  assign ld_val   = LD_FULL ? FULL_BCD : LD_SHORT ? SHORT_BCD : d_sat;
  assign go       = RUN && (state == S_RUN || (state == S_STOP && !q_zero));
  assign wrap     = presc == PW'(TICK_DIV - 1);
  always_ff @(posedge CP) begin
    if (CR) begin
      Q       <= FULL_BCD;
      state   <= S_STOP;
      presc   <= '0;
      bcnt    <= '0;
      TICK    <= 1'b0;
      TC      <= 1'b0;
      BUZZ    <= 1'b0;
      RUNNING <= 1'b0;
    end else if (ld) begin
      Q       <= ld_val;
      state   <= RUN && ld_val != '0 ? S_RUN : S_STOP;
      presc   <= '0;
      bcnt    <= '0;
      TICK    <= 1'b0;
      TC      <= 1'b0;
      BUZZ    <= 1'b0;
      RUNNING <= RUN && ld_val != '0;
    end else begin
      TICK <= go && wrap;
      if (bcnt != '0) bcnt <= bcnt - 1'b1;
      else BUZZ <= 1'b0;
      if (go) begin
        presc   <= wrap ? '0 : presc + 1'b1;
        state   <= wrap && dec_zero ? S_EXPIRED : S_RUN;
        RUNNING <= !(wrap && dec_zero);
        if (wrap) Q <= q_dec;
        if (wrap && dec_zero) begin
          TC   <= 1'b1;
          BUZZ <= 1'b1;
          bcnt <= BW'(BUZZ_CYCLES - 1);
        end
      end else if (state == S_RUN) begin
        state   <= S_STOP;
        RUNNING <= 1'b0;
      end
    end
  end
endmodule

// File: doc/bcd_shot_clock.md
Name: bcd_shot_clock

Overview:
- Parametrised BCD down-counting shot clock; successor to the fixed two-digit 24-count BCD counter pair.
- Adds N-digit BCD width, full and short reload presets, an internal tick prescaler, a run/pause/expired state machine and a timed buzzer pulse.
- Sits between the 7-segment display drivers (Q) and the game-control buttons (RUN, LD_FULL, LD_SHORT, PE/D).

Parameters:
- DIGITS, 2, number of BCD digits; Q and D are 4*DIGITS bits wide.
- PRESET_FULL, 24, full reload value, decimal, < 10^DIGITS.
- PRESET_SHORT, 14, short reload value, decimal, <= PRESET_FULL.
- SHORT_ONLY_IF_LESS, 1, when 1, LD_SHORT loads only if the current count < PRESET_SHORT.
- TICK_DIV, 50_000_000, CP cycles per count decrement; >= 2.
- BUZZ_CYCLES, 100_000_000, length of the BUZZ pulse in CP cycles; >= 1.

Ports:
- CP  in  1  clock, rising edge.
- CR  in  1  synchronous active-high reset.
- RUN  in  1  level; 1 = count, 0 = pause.
- LD_FULL  in  1  load PRESET_FULL (single-cycle strobe).
- LD_SHORT  in  1  load PRESET_SHORT, conditional (single-cycle strobe).
- PE  in  1  parallel load of D (single-cycle strobe).
- D  in  4*DIGITS  BCD load value; digit i is at bits [4i+3:4i].
- Q  out  4*DIGITS  current BCD count.
- TICK  out  1  one-cycle pulse on every decrement.
- TC  out  1  level; high while the count is zero in the EXPIRED state.
- BUZZ  out  1  high for BUZZ_CYCLES on entry to EXPIRED.
- RUNNING  out  1  high in the RUN state.

Behaviour:
- Reset (CR=1 at a CP edge):
  - Q = PRESET_FULL in BCD, state = STOP, prescaler = 0.
  - TICK = TC = BUZZ = RUNNING = 0.
  - CR has absolute priority, including mid-count and mid-buzz.
- States and transitions:
  - STOP: count held. RUN=1 and Q != 0 -> RUN. RUN=1 and Q == 0 -> stays STOP.
  - RUN: the prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 the prescaler wraps to 0, TICK=1 and Q decrements by one BCD.
    - RUN=0 -> STOP. The prescaler value is held, so resuming finishes the partial second.
    - A decrement that produces Q == 0 -> EXPIRED in the same edge.
  - EXPIRED: TC=1; Q holds 0. RUN is ignored. Exits only via CR or a load.
- Load priority, evaluated each edge after CR: LD_FULL > LD_SHORT > PE > count.
  - Any successful load:
    - sets Q, clears the prescaler and TICK;
    - sets state = STOP, or RUN if RUN=1 and the new Q != 0;
    - clears BUZZ and TC.
  - A load that coincides with a terminal decrement wins: no EXPIRED entry, no BUZZ.
- LD_SHORT condition:
  - SHORT_ONLY_IF_LESS=1 and Q >= PRESET_SHORT: the load is ignored and the strobe is not re-evaluated as PE.
  - SHORT_ONLY_IF_LESS=0: unconditional load.
- PE with an invalid BCD digit in D (any nibble > 9): that digit loads as 9 (saturation, per digit).
- BCD decrement:
  - Digit 0 decrements.
  - A digit at 0 wraps to 9 and borrows from the next digit.
  - All-zero never decrements.
- TICK is registered, coincident with the Q update.
- Latencies:
  - Q changes on the same edge as the accepted load.
  - The first decrement after entering RUN from a cleared prescaler occurs exactly TICK_DIV cycles later.
- BUZZ:
  - Asserted on the edge that enters EXPIRED.
  - Deasserted after exactly BUZZ_CYCLES cycles, or earlier on CR or a load.
- RUNNING = (state == RUN), registered.

Decomposition:
- Package bcd_clock_pkg:
  - state enum {STOP, RUN, EXPIRED};
  - function to_bcd(int) used to derive the preset BCD constants;
  - function bcd_sat(nibble).
- Sub-module bcd_dec_digit:
  - Purely combinational single-digit decrement with borrow-in/borrow-out.
  - Instantiated DIGITS times in a generate loop.
- Top level holds the FSM, the prescaler and the buzz counter.

Test Plan (DIGITS=2, TICK_DIV=4, BUZZ_CYCLES=3):
1. Reset, then RUN=1 for 8 cycles -> Q 24 -> 23 -> 22; TICK pulses at cycles 4 and 8; RUNNING=1.
2. Load via PE, D=0x10, RUN=1 -> Q 10 -> 09 (borrow across digits) -> … -> 00. On the 00 edge: TC=1, BUZZ high for exactly 3 cycles, RUNNING=0.
3. Pause/resume: RUN=0 two cycles after a tick, hold 10 cycles, RUN=1 -> the next decrement occurs exactly 2 cycles after resume; Q is unchanged during the pause.
4. Short reload:
   - LD_SHORT at Q=20 -> ignored, Q stays 20.
   - LD_SHORT at Q=09 -> Q=14, prescaler cleared.
   - LD_FULL and LD_SHORT together -> Q=24.
5. Simultaneous events:
   - LD_FULL on the edge that would decrement 01 -> 00 -> Q=24, no TC, no BUZZ.
   - CR asserted during BUZZ -> BUZZ=0, Q=24 next edge.
6. PE with D=0xA3 -> Q=0x93. In EXPIRED, RUN=1 with no load -> Q stays 00.
